// File: rtl/pst_score_sequencer.sv
// Walks a 64-entry signed piece-square map against a piece bitboard, one square per cycle,
// and accumulates the positional score of the occupied squares (rank-mirrored for black).
module pst_score_sequencer #(
    parameter int ENTRY_W    = 6,
    parameter int SUM_W      = 12,
    parameter int EARLY_EXIT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [63:0]             bitboard,
    input  logic                    flip,
    input  logic [64*ENTRY_W-1:0]   map_data,
    output logic                    busy,
    output logic                    done,
    output logic signed [SUM_W-1:0] score,
    output logic [6:0]              count
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [63:0]               bb;
    logic                      flp;
    logic [5:0]                idx;
    logic [5:0]                sel;
    logic signed [ENTRY_W-1:0] entry;
    logic signed [SUM_W-1:0]   entry_ext;
    logic                      last;

    function automatic logic signed [SUM_W-1:0] sext(input logic signed [ENTRY_W-1:0] v);
        return {{(SUM_W-ENTRY_W){v[ENTRY_W-1]}}, v};
    endfunction

    // Black reads the rank-mirrored square: XOR with 56 flips the rank bits only.
    assign sel       = idx ^ (flp ? 6'd56 : 6'd0);
    assign entry     = map_data[int'(sel)*ENTRY_W +: ENTRY_W];
    assign entry_ext = sext(entry);

    // Early exit looks at the board after this shift, so the current square still counts.
    assign last = (idx == 6'd63) || ((EARLY_EXIT != 0) && ((bb >> 1) == 64'd0));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bb    <= '0;
            flp   <= 1'b0;
            idx   <= '0;
            score <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        bb    <= bitboard;
                        flp   <= flip;
                        idx   <= '0;
                        score <= '0;
                        count <= '0;
                    end
                end
                SCAN: begin
                    if (bb[0]) begin
                        score <= score + entry_ext;
                        count <= count + 7'd1;
                    end
                    bb  <= bb >> 1;
                    idx <= idx + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pst_score_sequencer.sv
// Scoreboard bench for pst_score_sequencer: one instance per EARLY_EXIT setting share the stimulus;
// expected results come from a square-by-square reference sum.
module tb_pst_score_sequencer;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [63:0]         bitboard;
    logic                flip;
    logic [383:0]        map_data;
    logic                busy0, done0, busy1, done1;
    logic signed [11:0]  score0, score1;
    logic [6:0]          count0, count1;

    always #5 clk = ~clk;

    pst_score_sequencer #(.ENTRY_W(6), .SUM_W(12), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bitboard(bitboard), .flip(flip),
        .map_data(map_data), .busy(busy0), .done(done0), .score(score0), .count(count0));

    pst_score_sequencer #(.ENTRY_W(6), .SUM_W(12), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bitboard(bitboard), .flip(flip),
        .map_data(map_data), .busy(busy1), .done(done1), .score(score1), .count(count1));

    typedef struct {
        int score;
        int count;
        int lat;
        int acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int entry_of(input int i);
        logic signed [5:0] v;
        v = map_data[i*6 +: 6];
        return int'(v);
    endfunction

    // Reference: plain sum over occupied squares; latency from the highest occupied square.
    function automatic exp_t model(input logic [63:0] bb, input logic f, input bit ee, input int acc);
        exp_t e;
        e.score = 0;
        e.count = 0;
        e.lat   = ee ? 1 : 64;
        e.acc   = acc;
        for (int n = 0; n < 64; n++) begin
            if (bb[n]) begin
                e.score += entry_of(f ? (n ^ 56) : n);
                e.count++;
                if (ee) e.lat = n + 1;
            end
        end
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done0) begin
            if (q0.size() == 0) chk("ee0 unexpected done", 1, 0);
            else begin
                e = q0.pop_front();
                chk("ee0 score", int'(score0), e.score);
                chk("ee0 count", int'(count0), e.count);
                chk("ee0 latency", cyc - e.acc, e.lat);
            end
        end
        if (rst_n && done1) begin
            if (q1.size() == 0) chk("ee1 unexpected done", 1, 0);
            else begin
                e = q1.pop_front();
                chk("ee1 score", int'(score1), e.score);
                chk("ee1 count", int'(count1), e.count);
                chk("ee1 latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while ((busy0 || busy1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("pass timeout", t, 0);
    endtask

    task automatic run(input logic [63:0] bb, input logic f, input bit extra_start);
        int acc;
        @(negedge clk);
        bitboard = bb;
        flip     = f;
        start    = 1'b1;
        acc      = cyc + 1;
        q0.push_back(model(bb, f, 1'b0, acc));
        q1.push_back(model(bb, f, 1'b1, acc));
        @(negedge clk);
        start = 1'b0;
        if (extra_start) begin
            repeat (4) @(negedge clk);
            bitboard = ~bb;
            flip     = ~f;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
        @(negedge clk);
        chk("ee0 queue drained", q0.size(), 0);
        chk("ee1 queue drained", q1.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy0"},  int'(busy0),  0);
        chk({tag, " done0"},  int'(done0),  0);
        chk({tag, " score0"}, int'(score0), 0);
        chk({tag, " count0"}, int'(count0), 0);
        chk({tag, " busy1"},  int'(busy1),  0);
        chk({tag, " done1"},  int'(done1),  0);
        chk({tag, " score1"}, int'(score1), 0);
        chk({tag, " count1"}, int'(count1), 0);
    endtask

    task automatic random_map();
        for (int n = 0; n < 64; n++) map_data[n*6 +: 6] = 6'($urandom_range(0, 63));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rb;
        rst_n    = 1'b0;
        start    = 1'b1;
        bitboard = '1;
        flip     = 1'b0;
        map_data = '0;
        for (int n = 0; n < 64; n++) map_data[n*6 +: 6] = 6'(n - 32);
        repeat (3) @(negedge clk);
        check_zero("reset");
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post-reset idle");

        // Linear map n-32: a1 = -32, mirrored a1 reads a8 = 24.
        run(64'h1, 1'b0, 1'b0);
        run(64'h1, 1'b1, 1'b0);

        // Extreme maps over a full board.
        for (int n = 0; n < 64; n++) map_data[n*6 +: 6] = 6'h20;
        run('1, 1'b0, 1'b0);
        for (int n = 0; n < 64; n++) map_data[n*6 +: 6] = 6'h1f;
        run('1, 1'b1, 1'b0);

        // Rook-style corners, then empty board.
        random_map();
        map_data[0*6 +: 6] = 6'd0;
        map_data[7*6 +: 6] = 6'd0;
        map_data[3*6 +: 6] = 6'd5;
        run(64'h81, 1'b0, 1'b0);
        run(64'h0, 1'b0, 1'b0);
        run(64'h0, 1'b1, 1'b0);

        // Start during SCAN is ignored.
        random_map();
        rb = {$urandom, $urandom};
        run(rb | 64'h8000_0000_0000_0000, 1'($urandom_range(0, 1)), 1'b1);

        // Reset mid-pass: outputs clear immediately, no done, then a clean pass.
        @(negedge clk);
        bitboard = '1;
        flip     = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("mid-pass reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("after mid-pass reset");
        run('1, 1'b1, 1'b0);

        // Random maps and boards of varying density.
        for (int i = 0; i < 24; i++) begin
            random_map();
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rb = rb & {$urandom, $urandom};
                1: rb = rb >> $urandom_range(0, 63);
                2: rb = 64'h1 << $urandom_range(0, 63);
                default: ;
            endcase
            run(rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) && rb[63]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
